// File: rtl/rs_dispatch_scheduler.sv
// -----------------------------------------------------------------------------
// rs_dispatch_scheduler
//   Reservation-station storage and scheduler between the instruction issuer
//   and the ALU. Each edge it can accept one renamed instruction, wake up
//   waiting operands from the CDB, and dispatch one ready entry to the ALU.
//
// Optional feature macro: RS_AGE_PRIORITY_EN
//   defined   : per-entry 8-bit age; the oldest ready entry is selected first
//               (ties go to the lowest index)
//   undefined : no age storage; the lowest-index ready entry is selected
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   rdy                global ready; low freezes all state and outputs
//   in_*               issue slot (valid, opcode, operands/tags, rob, imm, pc)
//   full               stall to IF/issuer (one spare entry kept)
//   cdb_*              common data bus broadcast (valid, tag, value)
//   flush              misprediction flush, frees every entry
//   alu_*              dispatched instruction; alu_valid is a one-cycle pulse
// -----------------------------------------------------------------------------
module rs_dispatch_scheduler #(
   parameter int DEPTH = 16,
   parameter int ROB_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             in_valid,
   input  logic [5:0]       in_opcode,
   input  logic [31:0]      in_val1,
   input  logic [ROB_W-1:0] in_dep1,
   input  logic             in_has_dep1,
   input  logic [31:0]      in_val2,
   input  logic [ROB_W-1:0] in_dep2,
   input  logic             in_has_dep2,
   input  logic [ROB_W-1:0] in_rob_index,
   input  logic [31:0]      in_imm,
   input  logic [31:0]      in_pc,
   output logic             full,
   input  logic             cdb_valid,
   input  logic [ROB_W-1:0] cdb_rob_index,
   input  logic [31:0]      cdb_value,
   input  logic             flush,
   output logic             alu_valid,
   output logic [5:0]       alu_opcode,
   output logic [31:0]      alu_val1,
   output logic [31:0]      alu_val2,
   output logic [31:0]      alu_imm,
   output logic [31:0]      alu_pc,
   output logic [ROB_W-1:0] alu_rob_index
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   // Entry storage
   logic             busy_q   [DEPTH];
   logic [5:0]       opcode_q [DEPTH];
   logic [31:0]      val1_q   [DEPTH];
   logic [ROB_W-1:0] dep1_q   [DEPTH];
   logic             has1_q   [DEPTH];
   logic [31:0]      val2_q   [DEPTH];
   logic [ROB_W-1:0] dep2_q   [DEPTH];
   logic             has2_q   [DEPTH];
   logic [ROB_W-1:0] rob_q    [DEPTH];
   logic [31:0]      imm_q    [DEPTH];
   logic [31:0]      pc_q     [DEPTH];
`ifdef RS_AGE_PRIORITY_EN
   logic [7:0]       age_q    [DEPTH];
`endif

   logic [DEPTH-1:0] ready;
   logic [DEPTH-1:0] wake1;
   logic [DEPTH-1:0] wake2;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         assign ready[gi] = busy_q[gi] & ~has1_q[gi] & ~has2_q[gi];
         assign wake1[gi] = cdb_valid & busy_q[gi] & has1_q[gi] &
                            (dep1_q[gi] == cdb_rob_index);
         assign wake2[gi] = cdb_valid & busy_q[gi] & has2_q[gi] &
                            (dep2_q[gi] == cdb_rob_index);
      end
   endgenerate

   // Incoming operands matching the same-edge broadcast are captured as ready,
   // otherwise the wakeup would be lost.
   logic in_wake1;
   logic in_wake2;
   assign in_wake1 = cdb_valid & in_has_dep1 & (in_dep1 == cdb_rob_index);
   assign in_wake2 = cdb_valid & in_has_dep2 & (in_dep2 == cdb_rob_index);

   // Occupancy and stall
   logic [CNT_W-1:0] busy_count;
   always_comb begin
      busy_count = '0;
      for (int i = 0; i < DEPTH; i++) begin
         busy_count = busy_count + CNT_W'(busy_q[i]);
      end
   end
   assign full = (busy_count >= CNT_W'(DEPTH - 1));

   // Lowest-index free entry (scan downward so the last hit is the lowest)
   logic             free_found;
   logic [IDX_W-1:0] free_idx;
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   // Dispatch select
   logic             sel_found;
   logic [IDX_W-1:0] sel_idx;
`ifdef RS_AGE_PRIORITY_EN
   logic [7:0]       best_age;
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      best_age  = '0;
      // Strict '>' keeps the lowest index on equal ages.
      for (int i = 0; i < DEPTH; i++) begin
         if (ready[i] && (!sel_found || (age_q[i] > best_age))) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
            best_age  = age_q[i];
         end
      end
   end
`else
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (ready[i]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
      end
   end
`endif

   // State update. The insert slot is never busy, so it can never collide with
   // a wakeup, an age increment or the dispatched entry on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            busy_q[i] <= 1'b0;
         end
         alu_valid     <= 1'b0;
         alu_opcode    <= '0;
         alu_val1      <= '0;
         alu_val2      <= '0;
         alu_imm       <= '0;
         alu_pc        <= '0;
         alu_rob_index <= '0;
      end else if (rdy) begin
         if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
               busy_q[i] <= 1'b0;
            end
            alu_valid <= 1'b0;
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (wake1[i]) begin
                  has1_q[i] <= 1'b0;
                  val1_q[i] <= cdb_value;
               end
               if (wake2[i]) begin
                  has2_q[i] <= 1'b0;
                  val2_q[i] <= cdb_value;
               end
`ifdef RS_AGE_PRIORITY_EN
               if (busy_q[i] && (age_q[i] != 8'hFF)) begin
                  age_q[i] <= age_q[i] + 8'd1;
               end
`endif
            end

            if (sel_found) begin
               busy_q[sel_idx] <= 1'b0;
               alu_valid       <= 1'b1;
               alu_opcode      <= opcode_q[sel_idx];
               alu_val1        <= val1_q[sel_idx];
               alu_val2        <= val2_q[sel_idx];
               alu_imm         <= imm_q[sel_idx];
               alu_pc          <= pc_q[sel_idx];
               alu_rob_index   <= rob_q[sel_idx];
            end else begin
               alu_valid <= 1'b0;
            end

            // With no free entry the instruction is dropped.
            if (in_valid && free_found) begin
               busy_q[free_idx]   <= 1'b1;
               opcode_q[free_idx] <= in_opcode;
               dep1_q[free_idx]   <= in_dep1;
               has1_q[free_idx]   <= in_has_dep1 & ~in_wake1;
               val1_q[free_idx]   <= in_wake1 ? cdb_value : in_val1;
               dep2_q[free_idx]   <= in_dep2;
               has2_q[free_idx]   <= in_has_dep2 & ~in_wake2;
               val2_q[free_idx]   <= in_wake2 ? cdb_value : in_val2;
               rob_q[free_idx]    <= in_rob_index;
               imm_q[free_idx]    <= in_imm;
               pc_q[free_idx]     <= in_pc;
`ifdef RS_AGE_PRIORITY_EN
               age_q[free_idx]    <= 8'd0;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_rs_dispatch_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rs_dispatch_scheduler
//   Directed bench for rs_dispatch_scheduler with hand-computed expectations:
//   reset state, basic dispatch latency, CDB wakeup, same-edge insert+CDB,
//   rdy hold, full threshold, flush, and select priority (both macro modes).
// -----------------------------------------------------------------------------
module tb_rs_dispatch_scheduler;

   localparam int DEPTH = 16;
   localparam int ROB_W = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             rdy;
   logic             in_valid;
   logic [5:0]       in_opcode;
   logic [31:0]      in_val1;
   logic [ROB_W-1:0] in_dep1;
   logic             in_has_dep1;
   logic [31:0]      in_val2;
   logic [ROB_W-1:0] in_dep2;
   logic             in_has_dep2;
   logic [ROB_W-1:0] in_rob_index;
   logic [31:0]      in_imm;
   logic [31:0]      in_pc;
   logic             full;
   logic             cdb_valid;
   logic [ROB_W-1:0] cdb_rob_index;
   logic [31:0]      cdb_value;
   logic             flush;
   logic             alu_valid;
   logic [5:0]       alu_opcode;
   logic [31:0]      alu_val1;
   logic [31:0]      alu_val2;
   logic [31:0]      alu_imm;
   logic [31:0]      alu_pc;
   logic [ROB_W-1:0] alu_rob_index;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   rs_dispatch_scheduler #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .in_valid      (in_valid),
      .in_opcode     (in_opcode),
      .in_val1       (in_val1),
      .in_dep1       (in_dep1),
      .in_has_dep1   (in_has_dep1),
      .in_val2       (in_val2),
      .in_dep2       (in_dep2),
      .in_has_dep2   (in_has_dep2),
      .in_rob_index  (in_rob_index),
      .in_imm        (in_imm),
      .in_pc         (in_pc),
      .full          (full),
      .cdb_valid     (cdb_valid),
      .cdb_rob_index (cdb_rob_index),
      .cdb_value     (cdb_value),
      .flush         (flush),
      .alu_valid     (alu_valid),
      .alu_opcode    (alu_opcode),
      .alu_val1      (alu_val1),
      .alu_val2      (alu_val2),
      .alu_imm       (alu_imm),
      .alu_pc        (alu_pc),
      .alu_rob_index (alu_rob_index)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
   endtask

   // One clock edge; outputs are sampled 1 time unit after it, then the
   // one-shot inputs are returned to idle.
   task automatic step();
      @(posedge clk);
      #1;
      if (alu_valid)
         $display("dispatch: op=%0d rob=%0d val1=0x%0h val2=0x%0h", alu_opcode,
                  alu_rob_index, alu_val1, alu_val2);
      in_valid  = 1'b0;
      cdb_valid = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic set_ins(input int op, input logic [31:0] v1, input int d1, input logic h1,
                          input logic [31:0] v2, input int d2, input logic h2, input int rob);
      in_valid     = 1'b1;
      in_opcode    = 6'(op);
      in_val1      = v1;
      in_dep1      = ROB_W'(d1);
      in_has_dep1  = h1;
      in_val2      = v2;
      in_dep2      = ROB_W'(d2);
      in_has_dep2  = h2;
      in_rob_index = ROB_W'(rob);
      in_imm       = 32'h100 + 32'(rob);
      in_pc        = 32'h4000 + 32'(rob * 4);
   endtask

   task automatic set_cdb(input int tag, input logic [31:0] val);
      cdb_valid     = 1'b1;
      cdb_rob_index = ROB_W'(tag);
      cdb_value     = val;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; flush = 1'b0;
      in_valid = 1'b0; in_opcode = '0; in_val1 = '0; in_dep1 = '0; in_has_dep1 = 1'b0;
      in_val2 = '0; in_dep2 = '0; in_has_dep2 = 1'b0; in_rob_index = '0;
      in_imm = '0; in_pc = '0;
      cdb_valid = 1'b0; cdb_rob_index = '0; cdb_value = '0;
      step(); step();
      chk("rst_valid", 32'(alu_valid), 0);
      chk("rst_val1", alu_val1, 0);
      chk("rst_opcode", 32'(alu_opcode), 0);
      chk("rst_rob", 32'(alu_rob_index), 0);
      chk("rst_full", 32'(full), 0);
      rst = 1'b0;

      // Basic: ready insert dispatches on the following edge
      set_ins(5, 3, 0, 1'b0, 4, 0, 1'b0, 2);
      step();
      chk("t1_latency", 32'(alu_valid), 0);
      step();
      chk("t1_valid", 32'(alu_valid), 1);
      chk("t1_opcode", 32'(alu_opcode), 5);
      chk("t1_val1", alu_val1, 3);
      chk("t1_val2", alu_val2, 4);
      chk("t1_rob", 32'(alu_rob_index), 2);
      chk("t1_imm", alu_imm, 32'h102);
      chk("t1_pc", alu_pc, 32'h4008);
      step();
      chk("t1_pulse", 32'(alu_valid), 0);
      chk("t1_hold", alu_val1, 3);

      // CDB wakeup two cycles after insert
      set_ins(6, 0, 7, 1'b1, 8, 0, 1'b0, 3);
      step();
      step();
      chk("t2_wait", 32'(alu_valid), 0);
      set_cdb(7, 32'hDEAD);
      step();
      chk("t2_cdb_edge", 32'(alu_valid), 0);
      step();
      chk("t2_valid", 32'(alu_valid), 1);
      chk("t2_val1", alu_val1, 32'hDEAD);
      chk("t2_val2", alu_val2, 8);
      chk("t2_rob", 32'(alu_rob_index), 3);

      // Same-edge insert and CDB
      set_ins(7, 32'h11, 0, 1'b0, 0, 9, 1'b1, 4);
      set_cdb(9, 32'h55);
      step();
      chk("t3_ins_edge", 32'(alu_valid), 0);
      step();
      chk("t3_valid", 32'(alu_valid), 1);
      chk("t3_val2", alu_val2, 32'h55);
      chk("t3_val1", alu_val1, 32'h11);
      chk("t3_rob", 32'(alu_rob_index), 4);

      // rdy low freezes state and outputs
      set_ins(8, 1, 0, 1'b0, 2, 0, 1'b0, 33);
      step();
      rdy = 1'b0;
      step();
      chk("rdy_nodisp0", 32'(alu_valid), 0);
      step();
      chk("rdy_nodisp1", 32'(alu_valid), 0);
      rdy = 1'b1;
      step();
      chk("rdy_disp", 32'(alu_valid), 1);
      chk("rdy_disp_rob", 32'(alu_rob_index), 33);
      rdy = 1'b0;
      step();
      chk("rdy_hold_valid", 32'(alu_valid), 1);
      chk("rdy_hold_rob", 32'(alu_rob_index), 33);
      rdy = 1'b1;
      step();
      chk("rdy_release", 32'(alu_valid), 0);

      // Fill DEPTH-1 blocked entries, then drain via CDB
      for (int i = 0; i < DEPTH - 1; i++) begin
         set_ins(9, 0, 16 + i, 1'b1, 32'h200 + 32'(i), 0, 1'b0, i);
         step();
         if (i == DEPTH - 3) chk("t4_not_full", 32'(full), 0);
         if (i == DEPTH - 2) chk("t4_full", 32'(full), 1);
      end
      for (int k = 0; k < DEPTH - 1; k++) begin
         set_cdb(16 + k, 32'h300 + 32'(k));
         step();
         if (k == 0) begin
            chk("t4_full_hold", 32'(full), 1);
            chk("t4_no_disp", 32'(alu_valid), 0);
         end
         if (k == 1) chk("t4_full_drop", 32'(full), 0);
         if (k >= 1) begin
            chk("t4_drain_valid", 32'(alu_valid), 1);
            chk("t4_drain_rob", 32'(alu_rob_index), 32'(k - 1));
            chk("t4_drain_val1", alu_val1, 32'h300 + 32'(k - 1));
         end
      end
      step();
      chk("t4_last_rob", 32'(alu_rob_index), 32'(DEPTH - 2));
      chk("t4_last_valid", 32'(alu_valid), 1);
      step();
      chk("t4_empty", 32'(alu_valid), 0);

      // Flush with a simultaneous insert and CDB
      for (int i = 0; i < 5; i++) begin
         set_ins(10, 0, 40 + i, 1'b1, 0, 0, 1'b0, 10 + i);
         step();
      end
      set_ins(11, 5, 0, 1'b0, 6, 0, 1'b0, 20);
      set_cdb(40, 32'h77);
      flush = 1'b1;
      step();
      chk("t5_flush_valid", 32'(alu_valid), 0);
      chk("t5_flush_full", 32'(full), 0);
      step();
      chk("t5_ins_ignored", 32'(alu_valid), 0);
      for (int k = 0; k < 5; k++) begin
         set_cdb(40 + k, 32'h80 + 32'(k));
         step();
         chk("t5_after_cdb", 32'(alu_valid), 0);
      end
      step();
      chk("t5_after_cdb_last", 32'(alu_valid), 0);

      // Priority: B in slot 1 (older), C reuses slot 0 (younger)
      set_ins(12, 1, 0, 1'b0, 1, 0, 1'b0, 1);
      step();
      chk("t6_a_ins", 32'(alu_valid), 0);
      set_ins(13, 0, 51, 1'b1, 32'hB, 0, 1'b0, 2);
      step();
      chk("t6_a_disp", 32'(alu_valid), 1);
      chk("t6_a_rob", 32'(alu_rob_index), 1);
      set_ins(14, 0, 51, 1'b1, 32'hC, 0, 1'b0, 3);
      step();
      chk("t6_c_ins", 32'(alu_valid), 0);
      set_cdb(51, 32'h99);
      step();
      chk("t6_cdb_edge", 32'(alu_valid), 0);
      step();
      chk("t6_first_valid", 32'(alu_valid), 1);
`ifdef RS_AGE_PRIORITY_EN
      chk("t6_first_rob", 32'(alu_rob_index), 2);
      chk("t6_first_val2", alu_val2, 32'hB);
`else
      chk("t6_first_rob", 32'(alu_rob_index), 3);
      chk("t6_first_val2", alu_val2, 32'hC);
`endif
      step();
      chk("t6_second_valid", 32'(alu_valid), 1);
`ifdef RS_AGE_PRIORITY_EN
      chk("t6_second_rob", 32'(alu_rob_index), 3);
`else
      chk("t6_second_rob", 32'(alu_rob_index), 2);
`endif
      chk("t6_second_val1", alu_val1, 32'h99);
      step();
      chk("t6_done", 32'(alu_valid), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
